// File: rtl/mmu_pkg.sv
// mmu_pkg: shared refill FSM states, fault/PTE bit positions and field helpers
package mmu_pkg;
    typedef enum logic [2:0] {IDLE, CAPT, REQ, WAIT, WR, DONE, TRAP} refill_state_t;
    localparam int FLT_INS   = 4;
    localparam int FLT_SUP   = 3;
    localparam int FLT_WR    = 2;
    localparam int FLT_VALID = 1;
    localparam int PTE_W     = 2;
    localparam int PTE_V     = 1;
    localparam int ENTRY_WR  = 0;
    function automatic int untouched(input int va, input int nmmu);
        return va - $clog2(nmmu);
    endfunction
endpackage

// File: rtl/mmu_refill_sat_counter.sv
// mmu_refill_sat_counter: saturating event counter for performance statistics
module mmu_refill_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;
    // Count events, sticking at all-ones
    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (i_inc && r_count != '1)
            r_count <= r_count + 1'b1;
    end
    assign o_count = r_count;
endmodule

// File: rtl/mmu_refill.sv
// mmu_refill: hardware page-table refill engine driving the MMU register interface
module mmu_refill
    import mmu_pkg::*;
#(
    parameter int RV   = 16,
    parameter int PA   = RV,
    parameter int VA   = RV,
    parameter int NMMU = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          walk_enable,
    input  logic [PA-1:0] ptbase,
    input  logic          mmu_fault,
    input  logic [RV-1:0] mmu_reg_read,
    output logic          mmu_reg_write,
    output logic [RV-1:0] mmu_reg_data,
    output logic          mem_req,
    output logic [PA-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [RV-1:0] mem_rdata,
    output logic          busy,
    output logic          retry,
    output logic          sw_trap,
    output logic [15:0]   refill_count
);
    localparam int LOG = $clog2(NMMU);
    localparam int UT  = untouched(VA, NMMU);
    localparam int LB  = $clog2(4 * NMMU) + 1;

    refill_state_t r_state;
    logic          r_busy;
    logic          r_mem_req;
    logic [PA-1:0] r_mem_addr;
    logic          r_wr;
    logic [RV-1:0] r_data;
    logic          r_retry;
    logic          r_trap;
    logic [LOG+1:0] w_idx;
    logic [PA-1:0]  w_addr;
    logic           w_unused;

    // Each table slot is one 2-byte PTE; the table is aligned to its own size
    assign w_idx    = {mmu_reg_read[FLT_INS], mmu_reg_read[FLT_SUP], mmu_reg_read[UT +: LOG]};
    assign w_addr   = {ptbase[PA-1:LB], {LB{1'b0}}} + PA'({w_idx, 1'b0});
    assign w_unused = ^{mmu_reg_read, ptbase[LB-1:0], mem_rdata[0]};

    // Refill walk: capture fault, fetch PTE, write MMU entry, then retry or trap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_wr       <= 1'b0;
            r_data     <= '0;
            r_retry    <= 1'b0;
            r_trap     <= 1'b0;
        end else begin
            r_wr    <= 1'b0;
            r_retry <= 1'b0;
            r_trap  <= 1'b0;
            case (r_state)
                IDLE: if (mmu_fault) begin
                    r_state <= CAPT;
                    r_busy  <= 1'b1;
                end
                CAPT: if (mmu_reg_read[FLT_VALID] || !walk_enable) begin
                    r_state <= TRAP;
                    r_trap  <= 1'b1;
                end else begin
                    r_state    <= REQ;
                    r_mem_addr <= w_addr;
                    r_mem_req  <= 1'b1;
                end
                REQ: if (mem_gnt) begin
                    r_state   <= WAIT;
                    r_mem_req <= 1'b0;
                end
                WAIT: if (mem_rvalid) begin
                    if (!mem_rdata[PTE_V]) begin
                        r_state <= TRAP;
                        r_trap  <= 1'b1;
                    end else begin
                        r_state <= WR;
                        r_wr    <= 1'b1;
                        r_data  <= {mem_rdata[RV-1:1], 1'b1};
                    end
                end
                WR: begin
                    r_state <= DONE;
                    r_retry <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A new fault while the core is stalled is a protocol violation
    assert property (@(posedge clk) disable iff (reset) !(mmu_fault && r_busy));

    mmu_refill_sat_counter #(.W(16)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (r_retry),
        .o_count (refill_count)
    );

    assign busy          = r_busy;
    assign mem_req       = r_mem_req;
    assign mem_addr      = r_mem_addr;
    assign mmu_reg_write = r_wr;
    assign mmu_reg_data  = r_data;
    assign retry         = r_retry;
    assign sw_trap       = r_trap;
endmodule

// File: tb/tb_mmu_refill.sv
// tb_mmu_refill: timeline-model checker for the MMU refill engine
module tb_mmu_refill;
    localparam int N = 4096;
    logic        clk = 0, reset = 1, walk_enable = 0, mmu_fault = 0, mem_gnt = 0, mem_rvalid = 0;
    logic [15:0] ptbase = 0, mmu_reg_read = 0, mem_rdata = 0;
    logic        mmu_reg_write, mem_req, busy, retry, sw_trap;
    logic [15:0] mmu_reg_data, mem_addr, refill_count;
    int          cyc = 0, n_cmp = 0, n_bad = 0;
    bit          e_busy[N], e_req[N], e_wr[N], e_retry[N], e_trap[N];
    logic [15:0] e_addr[N], e_data[N], e_cnt[N];
    logic [15:0] m_cnt = 0;
    int          r_off, s_off, nw, nreq;
    logic [15:0] c_addr, c_data;

    mmu_refill dut (
        .clk(clk), .reset(reset), .walk_enable(walk_enable), .ptbase(ptbase),
        .mmu_fault(mmu_fault), .mmu_reg_read(mmu_reg_read), .mmu_reg_write(mmu_reg_write),
        .mmu_reg_data(mmu_reg_data), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy), .retry(retry),
        .sw_trap(sw_trap), .refill_count(refill_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) if (cyc >= 1 && cyc < N) begin
        chk("busy", 16'(busy), 16'(e_busy[cyc]));
        chk("mem_req", 16'(mem_req), 16'(e_req[cyc]));
        chk("reg_write", 16'(mmu_reg_write), 16'(e_wr[cyc]));
        chk("retry", 16'(retry), 16'(e_retry[cyc]));
        chk("sw_trap", 16'(sw_trap), 16'(e_trap[cyc]));
        chk("refill_count", refill_count, e_cnt[cyc]);
        if (e_req[cyc]) chk("mem_addr", mem_addr, e_addr[cyc]);
        if (e_wr[cyc]) chk("reg_data", mmu_reg_data, e_data[cyc]);
    end

    task automatic refill(input bit ins, input bit sup, input int vp, input bit prot,
                          input int gd, input int rd, input logic [15:0] pte, input bit stray,
                          input int rst_off, output int ro, output int so, output int w,
                          output int q, output logic [15:0] ca, output logic [15:0] cd);
        int t, last, tg, tv;
        bit walk, ok;
        logic [15:0] addr;
        t = cyc;
        ro = -1; so = -1; w = 0; q = 0; ca = 'x; cd = 'x;
        walk = !prot && walk_enable;
        ok   = walk && pte[1];
        tg   = t + 2 + gd;
        tv   = t + 3 + gd + rd;
        addr = (ptbase & 16'hFFC0) + 16'(2 * (ins * 16 + sup * 8 + vp));
        last = !walk ? t + 2 : (ok ? tv + 2 : tv + 1);
        for (int c = t + 1; c <= last; c++) e_busy[c] = 1;
        if (walk) for (int c = t + 2; c <= tg; c++) begin
            e_req[c]  = 1;
            e_addr[c] = addr;
        end
        if (!walk) e_trap[t + 2] = 1;
        else if (!ok) e_trap[tv + 1] = 1;
        else begin
            e_wr[tv + 1]    = 1;
            e_data[tv + 1]  = {pte[15:1], 1'b1};
            e_retry[tv + 2] = 1;
            m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 1;
            for (int c = tv + 3; c < N; c++) e_cnt[c] = m_cnt;
        end
        mmu_reg_read = {3'(vp), 8'b0, ins, sup, 1'b0, prot, 1'b0};
        mmu_fault = 1;
        tick;
        mmu_fault = 0;
        while (cyc <= last) begin
            if (rst_off >= 0 && cyc == t + rst_off) begin
                reset = 1;
                mem_gnt = 0;
                mem_rvalid = 0;
                for (int c = cyc + 1; c < N; c++) begin
                    e_busy[c] = 0; e_req[c] = 0; e_wr[c] = 0; e_retry[c] = 0; e_trap[c] = 0; e_cnt[c] = 0;
                end
                m_cnt = 0;
                tick;
                reset = 0;
                mem_rvalid = 1;
                mem_rdata = pte;
                if (mmu_reg_write) w++;
                tick;
                mem_rvalid = 0;
                if (mmu_reg_write) w++;
                return;
            end
            mem_gnt    = walk && cyc == tg;
            mem_rvalid = (walk && cyc == tv) || (stray && cyc == t + 2);
            mem_rdata  = (stray && cyc == t + 2) ? 16'h0000 : pte;
            if (retry && ro < 0) ro = cyc - t;
            if (sw_trap && so < 0) so = cyc - t;
            if (mmu_reg_write) begin w++; cd = mmu_reg_data; end
            if (mem_req) begin q++; ca = mem_addr; end
            tick;
        end
        mem_gnt = 0;
        mem_rvalid = 0;
    endtask

    initial begin
        for (int c = 0; c < N; c++) e_cnt[c] = 0;
        repeat (3) tick;
        chk("rst_count", refill_count, 16'h0000);
        chk("rst_addr", mem_addr, 16'h0000);
        reset = 0;
        walk_enable = 1;
        ptbase = 16'h4000;
        tick;
        // user data miss, page 3
        refill(0, 0, 3, 0, 0, 0, 16'hA006, 0, -1, r_off, s_off, nw, nreq, c_addr, c_data);
        chk("t1_addr", c_addr, 16'h4006);
        chk("t1_data", c_data, 16'hA007);
        chk("t1_retry_off", 16'(r_off), 16'd5);
        chk("t1_count", refill_count, 16'd1);
        // supervisor instruction miss, page 7, low ptbase bits ignored
        ptbase = 16'h4015;
        refill(1, 1, 7, 0, 0, 0, 16'h2002, 0, -1, r_off, s_off, nw, nreq, c_addr, c_data);
        chk("t2_addr", c_addr, 16'h403E);
        chk("t2_data", c_data, 16'h2003);
        chk("t2_retry_off", 16'(r_off), 16'd5);
        ptbase = 16'h4000;
        // invalid PTE traps
        refill(0, 0, 2, 0, 0, 0, 16'h8000, 0, -1, r_off, s_off, nw, nreq, c_addr, c_data);
        chk("t3_writes", 16'(nw), 16'd0);
        chk("t3_trap_off", 16'(s_off), 16'd4);
        chk("t3_busy_T5", 16'(busy), 16'd0);
        // protection fault
        refill(0, 1, 5, 1, 0, 0, 16'h0002, 0, -1, r_off, s_off, nw, nreq, c_addr, c_data);
        chk("t4_reqs", 16'(nreq), 16'd0);
        chk("t4_trap_off", 16'(s_off), 16'd2);
        // engine disabled
        walk_enable = 0;
        refill(0, 0, 1, 0, 0, 0, 16'h0002, 0, -1, r_off, s_off, nw, nreq, c_addr, c_data);
        chk("t5_reqs", 16'(nreq), 16'd0);
        chk("t5_trap_off", 16'(s_off), 16'd2);
        walk_enable = 1;
        // slow grant and data, stray rvalid while requesting
        refill(1, 0, 4, 0, 5, 3, 16'h1236, 1, -1, r_off, s_off, nw, nreq, c_addr, c_data);
        chk("t6_writes", 16'(nw), 16'd1);
        chk("t6_reqs", 16'(nreq), 16'd6);
        chk("t6_retry_off", 16'(r_off), 16'd13);
        chk("t6_data", c_data, 16'h1237);
        // reset in WAIT followed by a stale response
        refill(0, 0, 6, 0, 0, 3, 16'hC002, 0, 4, r_off, s_off, nw, nreq, c_addr, c_data);
        chk("t7_writes", 16'(nw), 16'd0);
        chk("t7_busy", 16'(busy), 16'd0);
        chk("t7_count", refill_count, 16'd0);
        chk("t7_data", mmu_reg_data, 16'h0000);
        // saturation from a preset near-full count
        dut.u_cnt.r_count = 16'hFFFE;
        m_cnt = 16'hFFFE;
        for (int c = cyc; c < N; c++) e_cnt[c] = 16'hFFFE;
        refill(0, 0, 0, 0, 0, 0, 16'h0002, 0, -1, r_off, s_off, nw, nreq, c_addr, c_data);
        chk("t8_count_a", refill_count, 16'hFFFF);
        refill(0, 0, 1, 0, 0, 0, 16'h0006, 0, -1, r_off, s_off, nw, nreq, c_addr, c_data);
        chk("t8_count_b", refill_count, 16'hFFFF);
        chk("t8_retry_off", 16'(r_off), 16'd5);
        repeat (3) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mmu_refill.md
Name: mmu_refill

Overview:
- Hardware refill engine for the paged MMU; the initiator side of the MMU register interface.
- On an MMU miss fault it reads the latched fault register and fetches the page-table entry (PTE) for the faulting {ins,sup,vpage} slot from memory.
- It writes that PTE into the MMU through the existing reg_write/reg_data path, then pulses retry.
- Invalid PTEs, protection faults, and refills while the engine is disabled go to a software trap.
- Sits between the MMU, the memory arbiter (low-priority requester) and the core's trap/stall logic.

Parameters:
- RV, 16, register/data width in bits
- PA, RV, physical address width
- VA, RV, virtual address width
- NMMU, 8, pages per MMU map; 4*NMMU entries total

Ports:
- clk  in  1  clock
- reset  in  1  reset
- walk_enable  in  1  hardware refill enabled; 0 sends every fault to trap
- ptbase  in  PA  byte address of the PTE table; bits [$clog2(4*NMMU):0] are ignored and treated as 0
- mmu_fault  in  1  one-cycle pulse; the MMU latches its fault register on this edge
- mmu_reg_read  in  RV  MMU fault register: [RV-1:UNTOUCHED] vpage, 4 ins, 3 sup, 2 write, 1 fault_valid(=prot)
- mmu_reg_write  out  1  one-cycle write strobe to the MMU
- mmu_reg_data  out  RV  write data; bit0 always 1 (entry write)
- mem_req  out  1  memory read request, held until mem_gnt
- mem_addr  out  PA  PTE byte address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  RV  PTE word
- busy  out  1  engine not idle; the core stalls
- retry  out  1  one-cycle pulse: refill complete, re-issue the access
- sw_trap  out  1  one-cycle pulse: take the MMU fault exception
- refill_count  out  16  saturating count of successful refills

Behaviour:
- UNTOUCHED = VA-$clog2(NMMU); IDX = {ins,sup,vpage}, width $clog2(NMMU)+2.
- Reset values: all outputs 0; FSM in IDLE; refill_count 0.
- FSM states: IDLE, CAPT, REQ, WAIT, WR, DONE, TRAP.
- IDLE:
  - mmu_fault=1 → CAPT, busy=1 from the next cycle.
- CAPT (fault register is valid this cycle):
  - If fault_valid=1 (protection fault) or walk_enable=0 → TRAP.
  - Otherwise register mem_addr = ptbase + IDX*2 (PA-bit, carry discarded) and the PTE format fields → REQ.
- REQ:
  - mem_req=1 with mem_addr stable until mem_gnt.
  - On the gnt cycle → WAIT; mem_req drops the next cycle.
- WAIT:
  - Wait for mem_rvalid, no timeout.
  - PTE bit1 (valid)=0 → TRAP; the MMU is not written.
  - Otherwise latch {mem_rdata[RV-1:1],1'b1} into mmu_reg_data → WR.
- WR:
  - mmu_reg_write=1 for exactly one cycle → DONE.
  - The MMU addresses the entry from its own fault register, so no address is driven.
  - PTE bit2 (writeable) passes through; the MMU ignores it for ins entries.
- DONE:
  - retry=1 for one cycle; refill_count increments unless at 0xFFFF → IDLE.
- TRAP:
  - sw_trap=1 for one cycle → IDLE.
  - The MMU fault register is never modified by this block.
- busy=1 in every state except IDLE, including the cycle retry or sw_trap pulses.
- mmu_reg_data holds its last value when not writing.
- Latency with mem_gnt in the REQ cycle and rvalid one cycle later: fault at T; CAPT T+1; REQ T+2; WAIT T+3; WR T+4; retry T+5.
- mmu_fault while busy is ignored; the core is stalled, so it is a protocol error, flagged by an assertion.
- mem_rvalid in any state other than WAIT is ignored.
- Reset mid-walk: immediate return to IDLE; mem_req, strobes and pulses drop that cycle. The memory side discards outstanding responses on the same reset.
- The mmu_reg_write strobe and a core-side software write never coincide, because the core is stalled while busy.

Decomposition:
- Shared package mmu_pkg:
  - refill state enum
  - bit-position constants FLT_INS=4, FLT_SUP=3, FLT_WR=2, FLT_VALID=1
  - PTE bits PTE_W=2, PTE_V=1, ENTRY_WR=0
  - UNTOUCHED computation function
- No sub-module needed.
- Optional tiny sat_counter for refill_count, reusable by other performance counters.

Test Plan (RV=16, NMMU=8, UNTOUCHED=13, ptbase=0x4000, gnt immediate, rvalid +1):
- User data read miss on va page 3, PTE 0xA006 → mem_addr=0x4006; mmu_reg_data=0xA007 pulsed at T+4; retry at T+5; refill_count=1.
- Supervisor instruction miss on page 7 (ins=1,sup=1) → IDX=31, mem_addr=0x403E; PTE 0x2002 → mmu_reg_data 0x2003, retry.
- PTE 0x8000 (valid=0) → no mmu_reg_write; sw_trap pulse at T+4; busy low at T+5.
- Protection fault (fault_valid=1) → no mem_req; sw_trap at T+2. walk_enable=0 with a miss → same response.
- mem_gnt delayed 5 cycles and rvalid delayed 3 more → mem_req and mem_addr stable throughout; exactly one mmu_reg_write and one retry.
- reset asserted in WAIT, then stale mem_rvalid → outputs 0 next cycle; IDLE; no write. With refill_count preset to 0xFFFF by 65535 refills, one more refill → stays 0xFFFF.
